// File: rtl/rps_match_engine_pkg.sv
// ----------------------------------------------------------------------------
// rps_pkg
//   Shared types for the stone/paper/scissors match engine: move codes,
//   round/match winner codes, FSM state encoding and the round judge.
// ----------------------------------------------------------------------------
package rps_pkg;

    typedef enum logic [1:0] {
        MOVE_STONE    = 2'b00,
        MOVE_PAPER    = 2'b01,
        MOVE_SCISSORS = 2'b10,
        MOVE_INVALID  = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        WIN_TIE     = 2'b00,
        WIN_P1      = 2'b01,
        WIN_P2      = 2'b10,
        WIN_INVALID = 2'b11
    } winner_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_EVAL   = 3'b001,
        ST_RESULT = 3'b010,
        ST_OVER   = 3'b100
    } state_t;

    // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Judge one round. Any invalid move voids the round.
    function automatic winner_t rps_judge(input move_t a, input move_t b);
        winner_t w;
        if (a == MOVE_INVALID || b == MOVE_INVALID) begin
            w = WIN_INVALID;
        end else if (a == b) begin
            w = WIN_TIE;
        end else if ((a == MOVE_STONE    && b == MOVE_SCISSORS) ||
                     (a == MOVE_PAPER    && b == MOVE_STONE)    ||
                     (a == MOVE_SCISSORS && b == MOVE_PAPER)) begin
            w = WIN_P1;
        end else begin
            w = WIN_P2;
        end
        return w;
    endfunction

endpackage

// File: rtl/rps_match_engine_if.sv
// ----------------------------------------------------------------------------
// rps_match_engine_if
//   Control/status bundle between the pin decode / status mux and the match
//   engine.
//   Controls (master -> slave): ena, p1_move, p2_move, start, mode, clear
//   Status   (slave -> master): state, round_winner, result_valid, p1_score,
//                               p2_score, rounds_played, match_done,
//                               match_winner, cpu_move
// ----------------------------------------------------------------------------
interface rps_match_engine_if #(
    parameter int unsigned SCORE_W = 4,
    parameter int unsigned ROUND_W = 6
);
    logic               ena;
    logic [1:0]         p1_move;
    logic [1:0]         p2_move;
    logic               start;
    logic               mode;
    logic               clear;

    logic [2:0]         state;
    logic [1:0]         round_winner;
    logic               result_valid;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [ROUND_W-1:0] rounds_played;
    logic               match_done;
    logic [1:0]         match_winner;
    logic [1:0]         cpu_move;

    modport master (
        output ena, p1_move, p2_move, start, mode, clear,
        input  state, round_winner, result_valid, p1_score, p2_score,
               rounds_played, match_done, match_winner, cpu_move
    );

    modport slave (
        input  ena, p1_move, p2_move, start, mode, clear,
        output state, round_winner, result_valid, p1_score, p2_score,
               rounds_played, match_done, match_winner, cpu_move
    );
endinterface

// File: rtl/rps_match_engine_lfsr.sv
// ----------------------------------------------------------------------------
// rps_lfsr
//   8-bit Galois LFSR providing the CPU opponent's move. Advances every
//   enabled cycle; frozen while ena=0.
//   Ports: clk, reset (async, active-high), ena, cpu_move (legal moves only)
// ----------------------------------------------------------------------------
module rps_lfsr
    import rps_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    output logic [1:0] cpu_move
);

    if (SEED == 8'h00) begin : g_bad_seed
        $error("rps_lfsr: SEED must be non-zero");
    end

    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (ena) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
        end
    end

    // Fold the illegal code 11 back onto stone/paper using bit 2.
    always_comb begin
        cpu_move = lfsr[1:0];
        if (lfsr[1:0] == 2'b11) begin
            cpu_move = {1'b0, lfsr[2]};
        end
    end

endmodule

// File: rtl/rps_match_engine.sv
// ----------------------------------------------------------------------------
// rps_match_engine
//   Multi-round stone/paper/scissors match controller. Latches both moves on
//   a start rising edge, judges the round, keeps scores and ends the match
//   when a player reaches WIN_ROUNDS. In mode=1 player 2 is the CPU LFSR.
//   Ports: clk, reset (async, active-high), bus (rps_match_engine_if.slave)
// ----------------------------------------------------------------------------
module rps_match_engine
    import rps_pkg::*;
#(
    parameter int unsigned SCORE_W    = 4,
    parameter int unsigned WIN_ROUNDS = 3,
    parameter int unsigned ROUND_W    = 6,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    rps_match_engine_if.slave  bus
);

    if (WIN_ROUNDS < 1 || WIN_ROUNDS >= (1 << SCORE_W)) begin : g_bad_win
        $error("rps_match_engine: WIN_ROUNDS must be in 1..2**SCORE_W-1");
    end

    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_ROUNDS);

    state_t             state;
    state_t             state_next;
    logic               start_q;
    logic               armed;
    logic               start_edge;
    move_t              move1_q;
    move_t              move2_q;
    winner_t            judged;
    winner_t            round_winner;
    winner_t            match_winner;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [ROUND_W-1:0] rounds_played;
    logic               p1_at_win;
    logic               p2_at_win;
    logic [1:0]         cpu_move;

    rps_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .ena      (bus.ena),
        .cpu_move (cpu_move)
    );

    // armed only sets once start has been seen low, so a start held high
    // through reset release is not mistaken for a fresh rising edge.
    assign start_edge = bus.start & ~start_q & armed;
    assign judged     = rps_judge(move1_q, move2_q);
    assign p1_at_win  = (p1_score == WIN_SCORE);
    assign p2_at_win  = (p2_score == WIN_SCORE);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (start_edge) state_next = ST_EVAL;
            ST_EVAL:   state_next = ST_RESULT;
            ST_RESULT: state_next = (p1_at_win || p2_at_win) ? ST_OVER : ST_IDLE;
            ST_OVER:   state_next = ST_OVER;
            default:   state_next = ST_IDLE;
        endcase
        if (bus.clear) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            start_q       <= 1'b0;
            armed         <= 1'b0;
            move1_q       <= MOVE_STONE;
            move2_q       <= MOVE_STONE;
            round_winner  <= WIN_TIE;
            match_winner  <= WIN_TIE;
            p1_score      <= '0;
            p2_score      <= '0;
            rounds_played <= '0;
        end else if (bus.ena) begin
            state   <= state_next;
            start_q <= bus.start;
            if (!bus.start) begin
                armed <= 1'b1;
            end
            if (bus.clear) begin
                p1_score      <= '0;
                p2_score      <= '0;
                rounds_played <= '0;
                match_winner  <= WIN_TIE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_edge) begin
                            move1_q <= move_t'(bus.p1_move);
                            move2_q <= bus.mode ? move_t'(cpu_move) : move_t'(bus.p2_move);
                        end
                    end
                    ST_EVAL: begin
                        round_winner <= judged;
                        if (judged != WIN_INVALID && rounds_played != '1) begin
                            rounds_played <= rounds_played + 1'b1;
                        end
                        if (judged == WIN_P1 && !p1_at_win) begin
                            p1_score <= p1_score + 1'b1;
                        end
                        if (judged == WIN_P2 && !p2_at_win) begin
                            p2_score <= p2_score + 1'b1;
                        end
                    end
                    ST_RESULT: begin
                        if (p1_at_win) begin
                            match_winner <= WIN_P1;
                        end else if (p2_at_win) begin
                            match_winner <= WIN_P2;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.state         = state;
    assign bus.round_winner  = round_winner;
    assign bus.result_valid  = (state == ST_RESULT);
    assign bus.p1_score      = p1_score;
    assign bus.p2_score      = p2_score;
    assign bus.rounds_played = rounds_played;
    assign bus.match_done    = (state == ST_OVER);
    assign bus.match_winner  = match_winner;
    assign bus.cpu_move      = cpu_move;

endmodule
